fml_burst_reader: RTL and testbench

Read-only FML master that fetches a linear run of 4-beat bursts from SDRAM, starting at a programmed base address, and streams the words out through a valid/ready interface. It sits directly upstream of `fmlarb`: its FML master port connects to one of the arbiter's `mN_*` slots. Its stream output feeds the pixel/packet pipeline, for example the DSI framebuffer feeder. An internal FIFO decouples bursty SDRAM returns from the downstream consumer.

---
 rtl/fml_pkg.sv | 24 ++
 rtl/fml_rd_fifo.sv | 123 ++++++++++++
 rtl/fml_burst_reader.sv | 174 +++++++++++++++++
 tb/tb_fml_burst_reader.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fml_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fml_pkg
// Description : Shared constants for the FML burst reader: burst length,
//               FSM state encoding and a helper that returns log2 of the
//               burst size in bytes for a given data width.
// Revision    : 1.0 - initial release
// ============================================================================
package fml_pkg;

    localparam int FML_BURST_LEN = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_REQ  = 2'd2;
    localparam logic [1:0] ST_BEAT = 2'd3;

    // Number of low byte-address bits covered by one burst.
    function automatic int burst_shift(input int width);
        return $clog2(FML_BURST_LEN * width / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fml_rd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fml_rd_fifo
// Description : Single-clock FIFO with a registered output stage.
//               A word written in cycle A is visible on o_rd_data with
//               o_rd_valid high in cycle A+1. Simultaneous read and write
//               are both honoured when full or empty. i_flush empties it.
// Ports       : clk/rst      - clock, async active-high reset
//               i_flush      - discard all contents
//               i_wr_en/data - push a word
//               i_rd_en      - pop the head word when o_rd_valid is high
//               o_rd_data    - head word (registered)
//               o_rd_valid   - head word present
//               o_free       - number of free slots
// Revision    : 1.0 - initial release
// ============================================================================
module fml_rd_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flush,
    input  logic                  i_wr_en,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic                  i_rd_en,
    output logic [WIDTH-1:0]      o_rd_data,
    output logic                  o_rd_valid,
    output logic [DEPTH_LOG2:0]   o_free
);

    localparam int                DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] C_DEPTH = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   mem_cnt_q, mem_cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [WIDTH-1:0]      out_data_q, out_data_d;

    logic                  w_pop;
    logic                  w_refill;
    logic                  w_mem_rd;
    logic                  w_mem_wr;
    logic                  w_bypass;
    logic [DEPTH_LOG2:0]   w_level;

    always_comb begin
        w_pop    = out_valid_q & i_rd_en;
        // The output register takes a new word whenever it is empty or popped.
        w_refill = ~out_valid_q | w_pop;
        w_mem_rd = w_refill & (mem_cnt_q != '0);
        // With storage empty, an incoming word goes straight to the output.
        w_bypass = w_refill & (mem_cnt_q == '0) & i_wr_en;
        w_mem_wr = i_wr_en & ~w_bypass;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_cnt_d   = mem_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (w_mem_wr) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        if (w_mem_rd) rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);

        case ({w_mem_wr, w_mem_rd})
            2'b10:   mem_cnt_d = mem_cnt_q + (DEPTH_LOG2 + 1)'(1);
            2'b01:   mem_cnt_d = mem_cnt_q - (DEPTH_LOG2 + 1)'(1);
            default: mem_cnt_d = mem_cnt_q;
        endcase

        if (w_mem_rd) begin
            out_valid_d = 1'b1;
            out_data_d  = mem[rd_ptr_q];
        end else if (w_bypass) begin
            out_valid_d = 1'b1;
            out_data_d  = i_wr_data;
        end else if (w_refill) begin
            out_valid_d = 1'b0;
        end

        if (i_flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            mem_cnt_d   = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_cnt_q   <= mem_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_wr && !i_flush) mem[wr_ptr_q] <= i_wr_data;
    end

    assign w_level    = mem_cnt_q + (DEPTH_LOG2 + 1)'(out_valid_q);
    assign o_free     = C_DEPTH - w_level;
    assign o_rd_data  = out_data_q;
    assign o_rd_valid = out_valid_q;

    // Upstream checks free space before requesting, so this must never fire.
    assert property (@(posedge clk) disable iff (rst)
        !(i_wr_en && !i_flush && !w_pop && (w_level == C_DEPTH)))
        else $error("fml_rd_fifo: write while full");

endmodule
`default_nettype wire

// File: rtl/fml_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : fml_burst_reader
// Description : Read-only FML master. Fetches count 4-beat bursts starting
//               at base_adr (burst aligned), buffers them in a FIFO and
//               streams the words out on a valid/ready interface.
// Ports       : sys_clk/sys_rst    - clock, async active-high reset
//               start/abort        - launch / cancel a transfer (pulses)
//               base_adr/count     - first address / burst count, on start
//               busy/done          - transfer active / last beat stored
//               fml_*              - FML master port (read only)
//               q_data/valid/ready - output stream
// Revision    : 1.0 - initial release
// ============================================================================
module fml_burst_reader
    import fml_pkg::*;
#(
    parameter int fml_depth       = 26,
    parameter int fml_width       = 32,
    parameter int fifo_depth_log2 = 5
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [fml_depth-1:0]   base_adr,
    input  logic [15:0]            count,
    output logic                   busy,
    output logic                   done,
    output logic [fml_depth-1:0]   fml_adr,
    output logic                   fml_stb,
    output logic                   fml_we,
    output logic [fml_width/8-1:0] fml_sel,
    input  logic                   fml_ack,
    input  logic [fml_width-1:0]   fml_di,
    output logic [fml_width-1:0]   fml_do,
    output logic [fml_width-1:0]   q_data,
    output logic                   q_valid,
    input  logic                   q_ready
);

    localparam int                       BURST_SHIFT  = burst_shift(fml_width);
    localparam logic [fml_depth-1:0]     BURST_BYTES  = fml_depth'(1) << BURST_SHIFT;
    localparam logic [fml_depth-1:0]     ADR_MASK     = ~(BURST_BYTES - fml_depth'(1));
    localparam logic [fifo_depth_log2:0] C_BURST_FREE = (fifo_depth_log2 + 1)'(FML_BURST_LEN);

    logic [1:0]           state_q, state_d;
    logic [fml_depth-1:0] adr_q, adr_d;
    logic [15:0]          remain_q, remain_d;
    logic [1:0]           beat_q, beat_d;
    logic                 stb_q, stb_d;
    logic                 abort_q, abort_d;
    logic                 done_q, done_d;

    logic                 w_aborting;
    logic                 w_fifo_wr;
    logic                 w_fifo_flush;
    logic [fifo_depth_log2:0] w_fifo_free;

    always_comb begin
        state_d      = state_q;
        adr_d        = adr_q;
        remain_d     = remain_q;
        beat_d       = beat_q;
        stb_d        = stb_q;
        abort_d      = abort_q;
        done_d       = 1'b0;
        w_fifo_wr    = 1'b0;
        w_fifo_flush = 1'b0;
        // An abort seen this cycle must already suppress this cycle's write.
        w_aborting   = abort_q | abort;

        case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                if (start) begin
                    if (count != 16'd0) begin
                        adr_d    = base_adr & ADR_MASK;
                        remain_d = count;
                        state_d  = ST_WAIT;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    remain_d     = 16'd0;
                    w_fifo_flush = 1'b1;
                    state_d      = ST_IDLE;
                end else if (w_fifo_free >= C_BURST_FREE) begin
                    stb_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // The strobe cannot be withdrawn, so an abort only marks the
                // burst for discard.
                if (abort) abort_d = 1'b1;
                if (fml_ack) begin
                    stb_d     = 1'b0;
                    w_fifo_wr = ~w_aborting;
                    beat_d    = 2'd1;
                    state_d   = ST_BEAT;
                end
            end
            default: begin // ST_BEAT
                if (abort) abort_d = 1'b1;
                w_fifo_wr = ~w_aborting;
                if (beat_q == 2'd3) begin
                    adr_d    = adr_q + BURST_BYTES;
                    remain_d = remain_q - 16'd1;
                    if (w_aborting) begin
                        remain_d     = 16'd0;
                        w_fifo_flush = 1'b1;
                        state_d      = ST_IDLE;
                    end else if (remain_q == 16'd1) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= ST_IDLE;
            adr_q    <= '0;
            remain_q <= 16'd0;
            beat_q   <= 2'd0;
            stb_q    <= 1'b0;
            abort_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            remain_q <= remain_d;
            beat_q   <= beat_d;
            stb_q    <= stb_d;
            abort_q  <= abort_d;
            done_q   <= done_d;
        end
    end

    fml_rd_fifo #(
        .WIDTH      (fml_width),
        .DEPTH_LOG2 (fifo_depth_log2)
    ) u_fifo (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .i_flush    (w_fifo_flush),
        .i_wr_en    (w_fifo_wr),
        .i_wr_data  (fml_di),
        .i_rd_en    (q_ready),
        .o_rd_data  (q_data),
        .o_rd_valid (q_valid),
        .o_free     (w_fifo_free)
    );

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign fml_adr = adr_q;
    assign fml_stb = stb_q;
    assign fml_we  = 1'b0;
    assign fml_sel = '1;
    assign fml_do  = '0;

endmodule
`default_nettype wire

// File: tb/tb_fml_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fml_burst_reader
// Description : Self-checking bench for fml_burst_reader. A small FML slave
//               model acks each strobe three cycles late and returns
//               address-derived data; expected addresses and words are
//               queued when a transfer is launched and compared as the DUT
//               produces them.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fml_burst_reader;

    localparam int ACK_DLY = 3;

    logic        sys_clk  = 1'b0;
    logic        sys_rst  = 1'b1;
    logic        start    = 1'b0;
    logic        abort    = 1'b0;
    logic [25:0] base_adr = '0;
    logic [15:0] count    = '0;
    logic        fml_ack  = 1'b0;
    logic [31:0] fml_di   = 32'hDEADBEEF;
    logic        q_ready  = 1'b0;

    logic        busy, done, fml_stb, fml_we, q_valid;
    logic [25:0] fml_adr;
    logic [3:0]  fml_sel;
    logic [31:0] fml_do, q_data;

    fml_burst_reader #(
        .fml_depth       (26),
        .fml_width       (32),
        .fifo_depth_log2 (3)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .start    (start),
        .abort    (abort),
        .base_adr (base_adr),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .fml_adr  (fml_adr),
        .fml_stb  (fml_stb),
        .fml_we   (fml_we),
        .fml_sel  (fml_sel),
        .fml_ack  (fml_ack),
        .fml_di   (fml_di),
        .fml_do   (fml_do),
        .q_data   (q_data),
        .q_valid  (q_valid),
        .q_ready  (q_ready)
    );

    always #5 sys_clk = ~sys_clk;

    int checks   = 0;
    int errors   = 0;
    int rx_cnt   = 0;
    int done_cnt = 0;
    int ack_cnt  = 0;

    logic [31:0] exp_data_q[$];
    logic [25:0] exp_adr_q[$];

    function automatic logic [31:0] beat_word(input logic [25:0] adr, input int beat);
        logic [25:0] a;
        a = adr + 26'(beat * 4);
        return 32'hA500_0000 ^ {6'd0, a};
    endfunction

    // Expected burst addresses and stream words for one transfer.
    task automatic push_transfer(input logic [25:0] base, input int n);
        logic [25:0] a;
        a = base & ~26'hF;
        for (int k = 0; k < n; k++) begin
            exp_adr_q.push_back(a);
            for (int b = 0; b < 4; b++) exp_data_q.push_back(beat_word(a, b));
            a = a + 26'd16;
        end
    endtask

    // ---------------- FML slave model ----------------
    int          beat_idx = 0;
    int          wcnt     = 0;
    logic [25:0] lat_adr  = '0;

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            fml_ack  = 1'b0;
            beat_idx = 0;
            wcnt     = 0;
        end else begin
            #1;
            fml_ack = 1'b0;
            if (beat_idx != 0) begin
                fml_di = beat_word(lat_adr, beat_idx);
                checks++;
                if (fml_stb !== 1'b0) begin
                    errors++;
                    $display("FAIL stb_low_during_beats: fml_stb=%b required 0", fml_stb);
                end
                beat_idx = (beat_idx == 3) ? 0 : beat_idx + 1;
            end else if (fml_stb === 1'b1) begin
                if (wcnt == ACK_DLY) begin
                    fml_ack  = 1'b1;
                    lat_adr  = fml_adr;
                    fml_di   = beat_word(fml_adr, 0);
                    beat_idx = 1;
                    wcnt     = 0;
                    ack_cnt++;
                    checks++;
                    if (exp_adr_q.size() == 0) begin
                        errors++;
                        $display("FAIL fml_adr_unexpected: got 0x%07h, required no request", fml_adr);
                    end else begin
                        logic [25:0] ea;
                        ea = exp_adr_q.pop_front();
                        if (fml_adr !== ea) begin
                            errors++;
                            $display("FAIL fml_adr: got 0x%07h, required 0x%07h", fml_adr, ea);
                        end
                    end
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // ---------------- stream / status monitor ----------------
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (done === 1'b1) begin
                done_cnt++;
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_with_done: busy=%b required 0", busy);
                end
            end
            if (busy === 1'b1) begin
                checks++;
                if ({fml_we, fml_sel, fml_do} !== {1'b0, 4'hF, 32'h0}) begin
                    errors++;
                    $display("FAIL tie_offs: we=%b sel=%h do=%h required 0/f/0", fml_we, fml_sel, fml_do);
                end
            end
            if (q_valid === 1'b1 && q_ready === 1'b1) begin
                rx_cnt++;
                checks++;
                if (exp_data_q.size() == 0) begin
                    errors++;
                    $display("FAIL q_data_unexpected: got 0x%08h, required no word", q_data);
                end else begin
                    logic [31:0] ed;
                    ed = exp_data_q.pop_front();
                    if (q_data !== ed) begin
                        errors++;
                        $display("FAIL q_data: got 0x%08h, required 0x%08h", q_data, ed);
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic pulse_start(input logic [25:0] a, input logic [15:0] n);
        base_adr = a;
        count    = n;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0;
        int i;
        d0 = done_cnt;
        i  = 0;
        while (done_cnt == d0 && i < budget) begin
            tick();
            i++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL %s_done_timeout: no done within %0d cycles, required one", name, budget);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if ({busy, fml_stb, done, q_valid, fml_adr, q_data} !== '0) begin
            errors++;
            $display("FAIL reset_values: busy=%b stb=%b done=%b qv=%b adr=%h qd=%h required all 0",
                     busy, fml_stb, done, q_valid, fml_adr, q_data);
        end
        sys_rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int r0, d0, a0;
        r0 = rx_cnt; d0 = done_cnt; a0 = ack_cnt;
        q_ready = 1'b1;
        push_transfer(26'h123, 2);
        pulse_start(26'h123, 16'd2);
        checks++;
        if (busy !== 1'b1 || fml_stb !== 1'b0) begin
            errors++;
            $display("FAIL basic_wait_cycle: busy=%b stb=%b required 1/0", busy, fml_stb);
        end
        tick();
        checks++;
        if (fml_stb !== 1'b1) begin
            errors++;
            $display("FAIL basic_stb_latency: fml_stb=%b required 1", fml_stb);
        end
        wait_done(60, "basic");
        repeat (4) tick();
        checks++;
        if (rx_cnt - r0 != 8 || done_cnt - d0 != 1 || ack_cnt - a0 != 2) begin
            errors++;
            $display("FAIL basic_counts: words=%0d done=%0d acks=%0d required 8/1/2",
                     rx_cnt - r0, done_cnt - d0, ack_cnt - a0);
        end
    endtask

    task automatic test_count_zero();
        int  d0, a0;
        logic stb_seen;
        d0 = done_cnt; a0 = ack_cnt;
        pulse_start(26'h500, 16'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: done=%b busy=%b required 1/0", done, busy);
        end
        stb_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (fml_stb !== 1'b0) stb_seen = 1'b1;
            tick();
        end
        checks++;
        if (stb_seen || done_cnt - d0 != 1 || ack_cnt != a0) begin
            errors++;
            $display("FAIL zero_no_traffic: stb_seen=%b done=%0d required 0/1", stb_seen, done_cnt - d0);
        end
    endtask

    task automatic test_backpressure();
        int r0, a0;
        r0 = rx_cnt; a0 = ack_cnt;
        q_ready = 1'b0;
        push_transfer(26'h1000, 4);
        pulse_start(26'h1000, 16'd4);
        repeat (40) tick();
        checks++;
        if (ack_cnt - a0 != 2 || fml_stb !== 1'b0 || busy !== 1'b1 || q_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall: acks=%0d stb=%b busy=%b qv=%b required 2/0/1/1",
                     ack_cnt - a0, fml_stb, busy, q_valid);
        end
        q_ready = 1'b1;
        wait_done(200, "bp");
        repeat (10) tick();
        checks++;
        if (rx_cnt - r0 != 16 || exp_data_q.size() != 0 || exp_adr_q.size() != 0) begin
            errors++;
            $display("FAIL bp_total: words=%0d left=%0d required 16/0", rx_cnt - r0, exp_data_q.size());
        end
    endtask

    task automatic test_abort_req();
        int  r0, d0, a0, i;
        logic stb_dropped;
        r0 = rx_cnt; d0 = done_cnt; a0 = ack_cnt;
        q_ready = 1'b1;
        exp_adr_q.push_back(26'h2000);
        pulse_start(26'h2000, 16'd3);
        i = 0;
        while (fml_stb !== 1'b1 && i < 10) begin
            tick();
            i++;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        stb_dropped = 1'b0;
        i = 0;
        while (ack_cnt == a0 && i < 20) begin
            if (fml_stb !== 1'b1) stb_dropped = 1'b1;
            tick();
            i++;
        end
        checks++;
        if (stb_dropped || ack_cnt - a0 != 1) begin
            errors++;
            $display("FAIL abort_stb_hold: dropped=%b acks=%0d required 0/1", stb_dropped, ack_cnt - a0);
        end
        i = 0;
        while (busy === 1'b1 && i < 20) begin
            tick();
            i++;
        end
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || q_valid !== 1'b0 || rx_cnt != r0 || done_cnt != d0) begin
            errors++;
            $display("FAIL abort_result: busy=%b qv=%b words=%0d done=%0d required 0/0/0/0",
                     busy, q_valid, rx_cnt - r0, done_cnt - d0);
        end
    endtask

    task automatic test_wrap();
        int r0;
        r0 = rx_cnt;
        q_ready = 1'b1;
        push_transfer(26'h3FF_FFF0, 2);
        pulse_start(26'h3FF_FFF0, 16'd2);
        wait_done(60, "wrap");
        repeat (4) tick();
        checks++;
        if (rx_cnt - r0 != 8 || exp_adr_q.size() != 0 || exp_data_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_total: words=%0d adr_left=%0d required 8/0", rx_cnt - r0, exp_adr_q.size());
        end
    endtask

    task automatic test_reset_mid_beat();
        int a0, r0, i;
        a0 = ack_cnt;
        q_ready = 1'b1;
        push_transfer(26'h3000, 2);
        pulse_start(26'h3000, 16'd2);
        i = 0;
        while (ack_cnt == a0 && i < 20) begin
            tick();
            i++;
        end
        tick();
        #1 sys_rst = 1'b1;
        #1;
        checks++;
        if ({busy, fml_stb, done, q_valid, fml_adr, q_data} !== '0) begin
            errors++;
            $display("FAIL midreset_values: busy=%b stb=%b done=%b qv=%b adr=%h qd=%h required all 0",
                     busy, fml_stb, done, q_valid, fml_adr, q_data);
        end
        exp_data_q.delete();
        exp_adr_q.delete();
        repeat (2) tick();
        sys_rst = 1'b0;
        tick();
        r0 = rx_cnt;
        push_transfer(26'h4440, 1);
        pulse_start(26'h4440, 16'd1);
        wait_done(40, "after_reset");
        repeat (4) tick();
        checks++;
        if (rx_cnt - r0 != 4 || exp_data_q.size() != 0 || exp_adr_q.size() != 0) begin
            errors++;
            $display("FAIL after_reset_total: words=%0d left=%0d required 4/0", rx_cnt - r0, exp_data_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_count_zero();
        test_backpressure();
        test_abort_req();
        test_wrap();
        test_reset_mid_beat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
